// File: rtl/root_latency_collector.sv
// Root-side latency collector: gathers one report per leaf for each test case and
// emits a max-latency summary word, plus running statistics and sticky error flags.
module root_latency_collector #(
  parameter int NUM_LEAVES = 1,
  parameter int LAT_W      = 16,
  parameter int SUM_W      = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [63:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [31:0]      case_count,
  output logic [LAT_W-1:0] worst_latency,
  output logic [SUM_W-1:0] latency_sum,
  output logic             err_dup,
  output logic             err_src,
  output logic [15:0]      dropped_count
);

  localparam logic [7:0] TYPE_REPORT  = 8'h01;
  localparam logic [7:0] TYPE_SUMMARY = 8'h02;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                state_reg;
  logic [NUM_LEAVES-1:0] seen_reg;
  logic [LAT_W-1:0]      max_reg;
  logic [23:0]           case_idx_reg;

  logic [7:0]            rx_type;
  logic [7:0]            rx_id;
  logic [LAT_W-1:0]      rx_lat;
  logic [NUM_LEAVES-1:0] id_hit;
  logic [NUM_LEAVES-1:0] seen_next;
  logic [LAT_W-1:0]      max_next;
  logic                  id_ok;
  logic                  is_dup;
  logic                  unused_rx_bits;

  assign rx_type = rx_data[63:56];
  assign rx_id   = rx_data[55:48];
  assign rx_lat  = rx_data[LAT_W-1:0];
  assign unused_rx_bits = ^rx_data[47:LAT_W];

  // One-hot decode of the source id; an all-zero result means the id is out of range.
  generate
    for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_id_hit
      assign id_hit[gi] = (rx_id == 8'(gi));
    end
  endgenerate

  assign id_ok     = |id_hit;
  assign is_dup    = |(id_hit & seen_reg);
  assign seen_next = seen_reg | id_hit;
  assign max_next  = (rx_lat > max_reg) ? rx_lat : max_reg;
  assign rx_ready  = (state_reg == COLLECT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= COLLECT;
      seen_reg      <= '0;
      max_reg       <= '0;
      case_idx_reg  <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      case_count    <= '0;
      worst_latency <= '0;
      latency_sum   <= '0;
      err_dup       <= 1'b0;
      err_src       <= 1'b0;
      dropped_count <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (rx_valid) begin
            if (rx_type != TYPE_REPORT) begin
              if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
            end else if (!id_ok) begin
              err_src <= 1'b1;
            end else if (is_dup) begin
              err_dup <= 1'b1;
            end else begin
              seen_reg <= seen_next;
              max_reg  <= max_next;
              // Last outstanding leaf: summary goes out on the very next cycle.
              if (&seen_next) begin
                state_reg <= EMIT;
                tx_valid  <= 1'b1;
                tx_data   <= {TYPE_SUMMARY, case_idx_reg, 16'h0000, 16'(max_next)};
              end
            end
          end
        end
        EMIT: begin
          if (tx_ready) begin
            case_count    <= case_count + 32'd1;
            latency_sum   <= latency_sum + SUM_W'(max_reg);
            worst_latency <= (max_reg > worst_latency) ? max_reg : worst_latency;
            case_idx_reg  <= case_idx_reg + 24'd1;
            seen_reg      <= '0;
            max_reg       <= '0;
            tx_valid      <= 1'b0;
            state_reg     <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_root_latency_collector.sv
// Bench for root_latency_collector: directed cases plus random traffic against a
// behavioural model (4 leaves), and a directed single-leaf instance.
module tb_root_latency_collector;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Four-leaf instance
  logic [63:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [63:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] case_count;
  logic [15:0] worst_latency;
  logic [47:0] latency_sum;
  logic        err_dup, err_src;
  logic [15:0] dropped_count;

  // Single-leaf instance
  logic [63:0] o_rx_data;
  logic        o_rx_valid, o_rx_ready;
  logic [63:0] o_tx_data;
  logic        o_tx_valid, o_tx_ready;
  logic [31:0] o_case_count;
  logic [15:0] o_worst;
  logic [47:0] o_sum;
  logic        o_err_dup, o_err_src;
  logic [15:0] o_dropped;

  root_latency_collector #(.NUM_LEAVES(NL), .LAT_W(16), .SUM_W(48)) u_dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .case_count(case_count), .worst_latency(worst_latency), .latency_sum(latency_sum),
    .err_dup(err_dup), .err_src(err_src), .dropped_count(dropped_count)
  );

  root_latency_collector #(.NUM_LEAVES(1), .LAT_W(16), .SUM_W(48)) u_one (
    .clk(clk), .reset(reset),
    .rx_data(o_rx_data), .rx_valid(o_rx_valid), .rx_ready(o_rx_ready),
    .tx_data(o_tx_data), .tx_valid(o_tx_valid), .tx_ready(o_tx_ready),
    .case_count(o_case_count), .worst_latency(o_worst), .latency_sum(o_sum),
    .err_dup(o_err_dup), .err_src(o_err_src), .dropped_count(o_dropped)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the four-leaf instance
  bit              m_pending;
  logic [63:0]     m_word;
  bit   [NL-1:0]   m_seen;
  int unsigned     m_max, m_idx, m_drop;
  longint unsigned m_count, m_worst, m_sum;
  bit              m_edup, m_esrc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rep(input int id, input int lat);
    logic [7:0]  idb;
    logic [15:0] lb;
    idb = 8'(id);
    lb  = 16'(lat);
    return {8'h01, idb, 32'h0, lb};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_word = '0; m_seen = '0; m_max = 0; m_idx = 0; m_drop = 0;
    m_count = 0; m_worst = 0; m_sum = 0; m_edup = 0; m_esrc = 0;
  endtask

  task automatic model_accept(input logic [63:0] w);
    int typ, id, lat;
    typ = int'(w[63:56]); id = int'(w[55:48]); lat = int'(w[15:0]);
    if (typ != 1) begin
      if (m_drop < 65535) m_drop++;
    end else if (id >= NL) begin
      m_esrc = 1;
    end else if (m_seen[id]) begin
      m_edup = 1;
    end else begin
      m_seen[id] = 1'b1;
      if (lat > m_max) m_max = lat;
      if (m_seen == {NL{1'b1}}) begin
        m_pending = 1;
        m_word = {8'h02, 24'(m_idx), 16'h0, 16'(m_max)};
      end
    end
  endtask

  task automatic model_handshake();
    longint unsigned lat;
    lat = longint'(m_word[15:0]);
    m_count++;
    m_sum = (m_sum + lat) & 64'h0000_FFFF_FFFF_FFFF;
    if (lat > m_worst) m_worst = lat;
    m_idx = (m_idx + 1) % (1 << 24);
    m_seen = '0; m_max = 0; m_pending = 0;
  endtask

  task automatic compare_all();
    chk("rx_ready", rx_ready, m_pending ? 1'b0 : 1'b1);
    chk("tx_valid", tx_valid, m_pending);
    if (m_pending) chk("tx_data", tx_data, m_word);
    chk("case_count", case_count, m_count[31:0]);
    chk("worst_latency", worst_latency, m_worst[15:0]);
    chk("latency_sum", latency_sum, m_sum[47:0]);
    chk("err_dup", err_dup, m_edup);
    chk("err_src", err_src, m_esrc);
    chk("dropped_count", dropped_count, 16'(m_drop));
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then compare.
  task automatic step(input logic [63:0] w, input bit v, input bit tr);
    bit acc, hs;
    rx_data = w; rx_valid = v; tx_ready = tr;
    acc = v && !m_pending;
    hs  = m_pending && tr;
    @(posedge clk);
    if (hs) model_handshake();
    else if (acc) model_accept(w);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rx_valid = 0; tx_ready = 0; rx_data = '0;
    reset = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_tx_data", tx_data, 64'h0);
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [15:0] lats1 [3];
    logic [63:0] got [$];
    logic [63:0] w, d;
    logic [63:0] exp1 [3];
    bit v, tr, acc1, hs1;
    int k;
    logic [7:0] typ;
    int id, lat;

    reset = 0; rx_data = '0; rx_valid = 0; tx_ready = 0;
    o_rx_data = '0; o_rx_valid = 0; o_tx_ready = 1;
    model_reset();
    #12;
    reset = 1;
    do_reset();
    chk("lit_reset_count", case_count, 32'd0);

    // Four reports, then a stalled summary with an rx word offered.
    step(rep(0, 10), 1, 0);
    step(rep(1, 25), 1, 0);
    step(rep(2, 7), 1, 0);
    step(rep(3, 25), 1, 0);
    chk("lit_caseA_data", tx_data, 64'h0200_0000_0000_0019);
    for (int i = 0; i < 5; i++) step(rep(0, 99), 1, 0);
    chk("lit_caseA_stable", tx_data, 64'h0200_0000_0000_0019);
    step(64'h0, 0, 1);
    chk("lit_caseA_count", case_count, 32'd1);
    chk("lit_caseA_sum", latency_sum, 48'd25);
    chk("lit_caseA_worst", worst_latency, 16'd25);

    // Duplicate id within a case is ignored.
    step(rep(1, 4), 1, 1);
    step(rep(1, 9), 1, 1);
    step(rep(0, 3), 1, 1);
    step(rep(2, 2), 1, 1);
    step(rep(3, 1), 1, 1);
    chk("lit_dup_data", tx_data, 64'h0200_0001_0000_0004);
    chk("lit_dup_flag", err_dup, 1'b1);
    step(64'h0, 0, 1);

    // Non-report word and out-of-range id.
    step({8'h05, 8'h00, 32'h0, 16'h0042}, 1, 1);
    step(rep(4, 50), 1, 1);
    chk("lit_dropped", dropped_count, 16'd1);
    chk("lit_err_src", err_src, 1'b1);
    chk("lit_no_summary", tx_valid, 1'b0);

    // Maximum latency compared unsigned.
    step(rep(0, 1), 1, 1);
    step(rep(1, 65535), 1, 1);
    step(rep(2, 32768), 1, 1);
    step(rep(3, 0), 1, 1);
    chk("lit_ffff_data", tx_data, 64'h0200_0002_0000_FFFF);
    step(64'h0, 0, 1);
    chk("lit_ffff_worst", worst_latency, 16'hFFFF);

    // Reset mid-case discards the partial case.
    step(rep(0, 200), 1, 1);
    step(rep(1, 300), 1, 1);
    do_reset();
    chk("lit_rst_err", {err_dup, err_src}, 2'b00);
    step(rep(3, 5), 1, 0);
    step(rep(2, 6), 1, 0);
    step(rep(1, 8), 1, 0);
    step(rep(0, 7), 1, 0);
    chk("lit_after_rst_data", tx_data, 64'h0200_0000_0000_0008);
    step(64'h0, 0, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      v   = ($urandom_range(0, 3) != 0);
      tr  = ($urandom_range(0, 2) != 0);
      typ = ($urandom_range(0, 15) == 0) ? 8'h05 : 8'h01;
      id  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      lat = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 65535));
      w   = rep(id, lat);
      w[63:56] = typ;
      w[47:16] = $urandom;
      step(w, v, tr);
    end
    for (int i = 0; i < 3; i++) step(64'h0, 0, 1);

    // Single-leaf instance: each report completes a case.
    lats1[0] = 16'd100; lats1[1] = 16'hFFFF; lats1[2] = 16'd1;
    exp1[0] = 64'h0200_0000_0000_0064;
    exp1[1] = 64'h0200_0001_0000_FFFF;
    exp1[2] = 64'h0200_0002_0000_0001;
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (k >= 3 && !o_tx_valid) break;
      o_rx_valid = (k < 3);
      o_rx_data  = (k < 3) ? rep(0, int'(lats1[k])) : 64'h0;
      o_tx_ready = 1;
      acc1 = o_rx_valid && o_rx_ready;
      hs1  = o_tx_valid;
      d    = o_tx_data;
      @(posedge clk);
      if (hs1) got.push_back(d);
      if (acc1) k++;
      #1;
    end
    o_rx_valid = 0;
    chk("one_summaries", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("one_summary_word", (i < got.size()) ? got[i] : 64'hxxxx_xxxx_xxxx_xxxx, exp1[i]);
    chk("one_worst", o_worst, 16'hFFFF);
    chk("one_sum", o_sum, 48'd65636);
    chk("one_count", o_case_count, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/root_latency_collector.md
Name: root_latency_collector

Overview:
- Sits directly downstream of the root hub's local receive path (parent FIFO output) and consumes the per-leaf latency reports produced after each decoded test case.
- Collects one report from every leaf for a test case and computes the case latency as the maximum over leaves.
- Emits one 64-bit summary word per case on a valid/ready stream and keeps running statistics plus sticky protocol-error flags for the controller and bench.

Parameters:
- NUM_LEAVES, 1, number of leaf FPGAs that report per test case (1..32).
- LAT_W, 16, latency field width in report and summary words.
- SUM_W, 48, width of the accumulated latency sum.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_data  input  64  report word from root hub receive stream.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  collector accepts rx_data this cycle.
- tx_data  output  64  summary word.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  downstream accepts summary.
- case_count  output  32  number of summaries accepted downstream.
- worst_latency  output  LAT_W  maximum case latency seen since reset.
- latency_sum  output  SUM_W  sum of all emitted case latencies, wraps modulo 2^SUM_W.
- err_dup  output  1  sticky: duplicate source id within one case.
- err_src  output  1  sticky: source id >= NUM_LEAVES.
- dropped_count  output  16  non-report words discarded, saturates at 16'hFFFF.

Behaviour:
- Input word format:
  - [63:56] type; 8'h01 = LATENCY report.
  - [55:48] source leaf id.
  - [15:0] latency.
  - Other bits are ignored.
- Output summary word:
  - [63:56] = 8'h02.
  - [55:32] = case index, 24 bits, starts at 0, wraps.
  - [31:16] = 0.
  - [15:0] = max latency.
- Transfers occur on valid && ready. tx_data and tx_valid come from registers.
- Reset (reset==0, asynchronous): state COLLECT; seen mask 0; running max 0; case index 0; tx_valid 0; tx_data 0; case_count 0; worst_latency 0; latency_sum 0; err_dup 0; err_src 0; dropped_count 0.
- State COLLECT, rx_ready = 1. For each accepted word:
  - type != 8'h01: discard; dropped_count +1, saturating.
  - id >= NUM_LEAVES: discard; err_src set.
  - seen[id] already 1: discard; err_dup set; the running max is unchanged.
  - Otherwise: seen[id] <= 1; running max <= max(running max, latency).
  - If this word makes seen all-ones, the next cycle is state EMIT with tx_valid = 1 and tx_data = summary using the updated max (1-cycle latency from the last report).
- State EMIT, rx_ready = 0, tx_valid held with stable tx_data until tx_ready.
  - On handshake: case_count +1; latency_sum += max; worst_latency = max(worst_latency, max); case index +1 (24-bit wrap); seen <= 0; running max <= 0; tx_valid <= 0; return to COLLECT.
  - A new word can be accepted on the cycle after the handshake. There is no overlap between consecutive cases.
- NUM_LEAVES = 1: every valid report completes a case immediately.
- A latency of 16'hFFFF is legal and is compared unsigned.
- Error flags and dropped_count clear only on reset.
- Reset asserted mid-case or mid-EMIT discards the partial case. The pending summary is never emitted.

Test Plan:
- NUM_LEAVES=4; reports id0..3 with latencies 10, 25, 7, 25 -> one summary 64'h0200_0000_0000_0019 one cycle after the 4th report; case_count=1; latency_sum=25; worst_latency=25.
- NUM_LEAVES=2; summary pending with tx_ready=0 for 5 cycles -> tx_data stable, rx_ready=0, an offered rx word is not consumed; tx_ready=1 -> handshake, next case index 1.
- NUM_LEAVES=2; reports id1=4, id1=9, id0=3 -> err_dup=1, summary latency 4 (duplicate ignored).
- Words with type 8'h05, and a report with id=2 when NUM_LEAVES=2 -> dropped_count=1, err_src=1, no summary, seen mask unchanged.
- NUM_LEAVES=1; 3 back-to-back reports 100, 65535, 1 with tx_ready=1 -> summaries with indices 0, 1, 2; worst_latency=65535; latency_sum=65636.
- Reset pulsed low after 2 of 4 reports -> all outputs return to 0; 4 fresh reports then produce a summary with case index 0.
